// File: rtl/idx_pkg.sv
// Shared types and default sizes for the index register file and its
// effective-address adder.
package idx_pkg;

    localparam int unsigned IDX_DEFAULT_WIDTH  = 8;
    localparam int unsigned IDX_DEFAULT_ADDR_W = 16;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        LOAD = 3'd1,
        INC  = 3'd2,
        DEC  = 3'd3,
        XFER = 3'd4
    } idx_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1,
        FIX  = 2'd2
    } ea_state_t;

endpackage

// File: rtl/index_ea_adder.sv
// Indexed effective-address adder: adds the low byte in one cycle and spends
// an extra FIX cycle propagating a carry into the high part.
module index_ea_adder
    import idx_pkg::*;
#(
    parameter int unsigned WIDTH  = IDX_DEFAULT_WIDTH,
    parameter int unsigned ADDR_W = IDX_DEFAULT_ADDR_W
) (
    input  logic              fclk,
    input  logic              reset,
    input  logic              ea_req,
    input  logic [WIDTH-1:0]  ea_idx,
    input  logic [ADDR_W-1:0] ea_base,
    output logic              ea_ready,
    output logic              ea_valid,
    output logic [ADDR_W-1:0] ea_addr,
    output logic              ea_page_cross
);

    localparam int unsigned HI_W = ADDR_W - WIDTH;

    ea_state_t         r_state;
    ea_state_t         w_state_nx;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  w_lo_nx;
    logic [HI_W-1:0]   r_hi;
    logic [HI_W-1:0]   w_hi_nx;
    logic              r_cross;
    logic              w_cross_nx;
    logic [WIDTH:0]    w_sum;

    always_ff @(posedge fclk) begin
        if (reset) begin
            r_state <= IDLE;
            r_lo    <= '0;
            r_hi    <= '0;
            r_cross <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_lo    <= w_lo_nx;
            r_hi    <= w_hi_nx;
            r_cross <= w_cross_nx;
        end
    end

    // Accept in IDLE or DONE (back-to-back); a low-part carry detours via FIX.
    always_comb begin
        w_state_nx = r_state;
        w_lo_nx    = r_lo;
        w_hi_nx    = r_hi;
        w_cross_nx = r_cross;
        w_sum      = {1'b0, ea_base[WIDTH-1:0]} + {1'b0, ea_idx};
        case (r_state)
            IDLE, DONE: begin
                if (ea_req) begin
                    w_lo_nx    = w_sum[WIDTH-1:0];
                    w_hi_nx    = ea_base[ADDR_W-1:WIDTH];
                    w_cross_nx = w_sum[WIDTH];
                    w_state_nx = w_sum[WIDTH] ? FIX : DONE;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            FIX: begin
                w_hi_nx    = r_hi + HI_W'(1);
                w_state_nx = DONE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign ea_ready      = (r_state == IDLE) || (r_state == DONE);
    assign ea_valid      = (r_state == DONE);
    assign ea_addr       = {r_hi, r_lo};
    assign ea_page_cross = r_cross;

endmodule

// File: rtl/index_register_file.sv
// Index register file (X, Y, ...) with LOAD/INC/DEC/XFER ops and N/Z flags.
// The effective-address path exists only when INDEX_EA_EN is defined.
module index_register_file
    import idx_pkg::*;
#(
    parameter int unsigned  WIDTH   = IDX_DEFAULT_WIDTH,
    parameter int unsigned  NUM_IDX = 2,
    parameter int unsigned  ADDR_W  = IDX_DEFAULT_ADDR_W,
    localparam int unsigned SEL_W   = $clog2(NUM_IDX)
) (
    input  logic              fclk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic [SEL_W-1:0]  op_sel,
    input  logic [SEL_W-1:0]  src_sel,
    input  logic [WIDTH-1:0]  db_in,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [WIDTH-1:0]  db_out,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_upd,
    input  logic              ea_req,
    input  logic [SEL_W-1:0]  ea_sel,
    input  logic [ADDR_W-1:0] ea_base,
    output logic              ea_ready,
    output logic              ea_valid,
    output logic [ADDR_W-1:0] ea_addr,
    output logic              ea_page_cross
);

    logic [WIDTH-1:0] r_regs [NUM_IDX];
    logic             r_flag_n;
    logic             r_flag_z;
    logic             r_flag_upd;

    idx_op_t          w_op;
    logic             w_op_ok;
    logic             w_src_ok;
    logic             w_rd_ok;
    logic             w_wr;
    logic [WIDTH-1:0] w_dst;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_result;

    assign w_op     = idx_op_t'(op);
    assign w_op_ok  = 32'(op_sel) < NUM_IDX;
    assign w_src_ok = 32'(src_sel) < NUM_IDX;
    assign w_rd_ok  = 32'(rd_sel) < NUM_IDX;
    assign w_dst    = w_op_ok  ? r_regs[op_sel]  : '0;
    assign w_src    = w_src_ok ? r_regs[src_sel] : '0;
    assign db_out   = w_rd_ok  ? r_regs[rd_sel]  : '0;

    // Result of the op; out-of-range selects and undefined opcodes write nothing.
    always_comb begin
        w_wr     = 1'b0;
        w_result = w_dst;
        case (w_op)
            LOAD: begin
                w_wr     = w_op_ok;
                w_result = db_in;
            end
            INC: begin
                w_wr     = w_op_ok;
                w_result = w_dst + WIDTH'(1);
            end
            DEC: begin
                w_wr     = w_op_ok;
                w_result = w_dst - WIDTH'(1);
            end
            XFER: begin
                w_wr     = w_op_ok && w_src_ok;
                w_result = w_src;
            end
            default: w_wr = 1'b0;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (reset) begin
            r_regs     <= '{default: '0};
            r_flag_n   <= 1'b0;
            r_flag_z   <= 1'b0;
            r_flag_upd <= 1'b0;
        end else begin
            r_flag_upd <= w_wr;
            if (w_wr) begin
                r_regs[op_sel] <= w_result;
                r_flag_n       <= w_result[WIDTH-1];
                r_flag_z       <= (w_result == '0);
            end
        end
    end

    assign flag_n   = r_flag_n;
    assign flag_z   = r_flag_z;
    assign flag_upd = r_flag_upd;

`ifdef INDEX_EA_EN
    logic [WIDTH-1:0] w_ea_idx;

    // Pre-edge register value, so a same-edge op write is not seen.
    assign w_ea_idx = (32'(ea_sel) < NUM_IDX) ? r_regs[ea_sel] : r_regs[0];

    index_ea_adder #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ea_adder (
        .fclk          (fclk),
        .reset         (reset),
        .ea_req        (ea_req),
        .ea_idx        (w_ea_idx),
        .ea_base       (ea_base),
        .ea_ready      (ea_ready),
        .ea_valid      (ea_valid),
        .ea_addr       (ea_addr),
        .ea_page_cross (ea_page_cross)
    );
`else
    logic w_ea_unused;

    assign w_ea_unused   = ^{ea_req, ea_sel, ea_base};
    assign ea_ready      = 1'b1;
    assign ea_valid      = 1'b0;
    assign ea_addr       = '0;
    assign ea_page_cross = 1'b0;
`endif

endmodule

// File: tb/tb_index_register_file.sv
// Directed plus randomized bench for index_register_file against an
// arithmetic reference model of the registers, flags and indexed addressing.
module tb_index_register_file;

    logic        fclk;
    logic        reset;
    logic [2:0]  op;
    logic        op_sel;
    logic        src_sel;
    logic [7:0]  db_in;
    logic        rd_sel;
    logic [7:0]  db_out;
    logic        flag_n;
    logic        flag_z;
    logic        flag_upd;
    logic        ea_req;
    logic        ea_sel;
    logic [15:0] ea_base;
    logic        ea_ready;
    logic        ea_valid;
    logic [15:0] ea_addr;
    logic        ea_page_cross;

    int n_checks = 0;
    int n_err    = 0;
    int m_reg [2];
    int m_n, m_z, m_upd;

    index_register_file #(
        .WIDTH   (8),
        .NUM_IDX (2),
        .ADDR_W  (16)
    ) dut (
        .fclk          (fclk),
        .reset         (reset),
        .op            (op),
        .op_sel        (op_sel),
        .src_sel       (src_sel),
        .db_in         (db_in),
        .rd_sel        (rd_sel),
        .db_out        (db_out),
        .flag_n        (flag_n),
        .flag_z        (flag_z),
        .flag_upd      (flag_upd),
        .ea_req        (ea_req),
        .ea_sel        (ea_sel),
        .ea_base       (ea_base),
        .ea_ready      (ea_ready),
        .ea_valid      (ea_valid),
        .ea_addr       (ea_addr),
        .ea_page_cross (ea_page_cross)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_reg[0] = 0; m_reg[1] = 0;
        m_n = 0; m_z = 0; m_upd = 0;
    endtask

    // Opcodes: 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 XFER, 5..7 undefined (no effect).
    task automatic model_op(input int o, input int s, input int src, input int d);
        int v;
        int wr;
        wr = 1;
        v  = 0;
        case (o)
            1: v = d % 256;
            2: v = (m_reg[s] + 1) % 256;
            3: v = (m_reg[s] + 255) % 256;
            4: v = m_reg[src];
            default: wr = 0;
        endcase
        if (wr != 0) begin
            m_reg[s] = v;
            m_n = (v >= 128) ? 1 : 0;
            m_z = (v == 0) ? 1 : 0;
        end
        m_upd = wr;
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic drive_op(input int o, input int s, input int src, input int d, input int rd);
        op      = 3'(o);
        op_sel  = 1'(s);
        src_sel = 1'(src);
        db_in   = 8'(d);
        rd_sel  = 1'(rd);
        #1 chk("db_out_pre", 32'(db_out), m_reg[rd]);
        @(posedge fclk);
        model_op(o, s, src, d);
        @(negedge fclk);
        chk("flag_n", 32'(flag_n), m_n);
        chk("flag_z", 32'(flag_z), m_z);
        chk("flag_upd", 32'(flag_upd), m_upd);
        chk("db_out_post", 32'(db_out), m_reg[rd]);
        op = 3'd0;
    endtask

`ifdef INDEX_EA_EN
    task automatic ea_run(input int sel, input int base, input int o, input int s, input int d);
        int idx, exp_addr, exp_cross, lat, src;
        idx       = m_reg[sel];
        exp_addr  = (base + idx) % 65536;
        exp_cross = ((base % 256) + idx > 255) ? 1 : 0;
        src       = int'($urandom_range(0, 1));
        ea_req  = 1'b1;
        ea_sel  = 1'(sel);
        ea_base = 16'(base);
        op      = 3'(o);
        op_sel  = 1'(s);
        src_sel = 1'(src);
        db_in   = 8'(d);
        #1 chk("ea_ready_accept", 32'(ea_ready), 1);
        @(posedge fclk);
        model_op(o, s, src, d);
        @(negedge fclk);
        ea_req = 1'b0;
        op     = 3'd0;
        chk("ea_op_flag_upd", 32'(flag_upd), m_upd);
        if (exp_cross != 0) chk("ea_ready_fix", 32'(ea_ready), 0);
        lat = 1;
        while (ea_valid !== 1'b1 && lat < 4) begin
            @(negedge fclk);
            lat++;
        end
        chk("ea_latency", lat, (exp_cross != 0) ? 2 : 1);
        chk("ea_addr", 32'(ea_addr), exp_addr);
        chk("ea_page_cross", 32'(ea_page_cross), exp_cross);
        @(negedge fclk);
        chk("ea_valid_pulse", 32'(ea_valid), 0);
    endtask
`endif

    initial begin
        reset   = 1'b1;
        op      = 3'd0;
        op_sel  = 1'b0;
        src_sel = 1'b0;
        db_in   = 8'd0;
        rd_sel  = 1'b0;
        ea_req  = 1'b0;
        ea_sel  = 1'b0;
        ea_base = 16'd0;
        model_reset();
        repeat (2) @(posedge fclk);
        @(negedge fclk);

        // Reset state.
        chk("rst_db_out_x", 32'(db_out), 0);
        rd_sel = 1'b1;
        #1 chk("rst_db_out_y", 32'(db_out), 0);
        chk("rst_flag_n", 32'(flag_n), 0);
        chk("rst_flag_z", 32'(flag_z), 0);
        chk("rst_flag_upd", 32'(flag_upd), 0);
        chk("rst_ea_ready", 32'(ea_ready), 1);
        chk("rst_ea_valid", 32'(ea_valid), 0);
        chk("rst_ea_addr", 32'(ea_addr), 0);
        chk("rst_ea_cross", 32'(ea_page_cross), 0);
        @(negedge fclk);
        reset = 1'b0;

        // LOAD X=0x80: negative, non-zero.
        drive_op(1, 0, 0, 'h80, 0);
        chk("load80_db", 32'(db_out), 'h80);
        chk("load80_n", 32'(flag_n), 1);
        chk("load80_z", 32'(flag_z), 0);
        chk("load80_upd", 32'(flag_upd), 1);

        // Y=0xFF, INC wraps to 0, DEC wraps back.
        drive_op(1, 1, 0, 'hFF, 1);
        drive_op(2, 1, 0, 0, 1);
        chk("inc_wrap_db", 32'(db_out), 0);
        chk("inc_wrap_z", 32'(flag_z), 1);
        drive_op(3, 1, 0, 0, 1);
        chk("dec_wrap_db", 32'(db_out), 'hFF);
        chk("dec_wrap_n", 32'(flag_n), 1);

        // Transfers, self-transfer, NOP and undefined opcode.
        drive_op(4, 0, 1, 0, 0);
        drive_op(4, 1, 1, 0, 1);
        chk("xfer_self_upd", 32'(flag_upd), 1);
        drive_op(0, 0, 0, 'h55, 0);
        chk("nop_upd", 32'(flag_upd), 0);
        drive_op(6, 1, 0, 'h33, 1);
        drive_op(1, 0, 0, 0, 0);
        drive_op(7, 0, 0, 'h12, 0);

        for (int i = 0; i < 150; i++) begin
            drive_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 1)));
        end

`ifdef INDEX_EA_EN
        drive_op(1, 0, 0, 'h10, 0);
        ea_run(0, 'h12F0, 0, 0, 0);
        chk("ea_cross_addr", 32'(ea_addr), 'h1300);
        drive_op(1, 0, 0, 'h05, 0);
        ea_run(0, 'h12F0, 0, 0, 0);
        chk("ea_nocross_addr", 32'(ea_addr), 'h12F5);

        // Same-edge INC X must not affect the captured index.
        ea_run(0, 'h1000, 2, 0, 0);
        chk("ea_old_x_addr", 32'(ea_addr), 'h1005);
        rd_sel = 1'b0;
        #1 chk("ea_x_incremented", 32'(db_out), 6);
        @(negedge fclk);

        drive_op(1, 0, 0, 'h01, 0);
        ea_run(0, 'hFFFF, 0, 0, 0);
        chk("ea_wrap_addr", 32'(ea_addr), 0);

        // Reset while in FIX, with an op on the reset edge.
        ea_req  = 1'b1;
        ea_sel  = 1'b0;
        ea_base = 16'hFFFF;
        @(posedge fclk);
        @(negedge fclk);
        ea_req = 1'b0;
        chk("fix_ready", 32'(ea_ready), 0);
        chk("fix_cross", 32'(ea_page_cross), 1);
        reset  = 1'b1;
        op     = 3'd1;
        op_sel = 1'b1;
        db_in  = 8'h77;
        @(posedge fclk);
        @(negedge fclk);
        reset = 1'b0;
        op    = 3'd0;
        model_reset();
        chk("rstfix_valid", 32'(ea_valid), 0);
        chk("rstfix_addr", 32'(ea_addr), 0);
        chk("rstfix_cross", 32'(ea_page_cross), 0);
        chk("rstfix_ready", 32'(ea_ready), 1);
        chk("rstfix_upd", 32'(flag_upd), 0);
        rd_sel = 1'b1;
        #1 chk("rstfix_y", 32'(db_out), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge fclk);
            chk("rstfix_no_valid", 32'(ea_valid), 0);
        end

        for (int i = 0; i < 25; i++) begin
            ea_run(int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 255)));
        end
`else
        ea_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ea_sel  = 1'($urandom_range(0, 1));
            ea_base = 16'($urandom_range(0, 65535));
            @(negedge fclk);
            chk("noea_ready", 32'(ea_ready), 1);
            chk("noea_valid", 32'(ea_valid), 0);
            chk("noea_addr", 32'(ea_addr), 0);
            chk("noea_cross", 32'(ea_page_cross), 0);
        end
        ea_req = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
